// File: rtl/ecg_pkg.sv
// Shared widths, detector state encoding and the BPM numerator helper
// for the ECG R-peak / R-R interval detector.
package ecg_pkg;

  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 13;
  localparam int BPM_W    = 8;
  localparam int DIV_W    = 16;

  typedef enum logic [1:0] {
    BELOW    = 2'd0,
    ABOVE    = 2'd1,
    REFRACT  = 2'd2,
    ARTIFACT = 2'd3
  } det_state_e;

  // Samples per minute: the dividend that turns an R-R interval into BPM.
  function automatic logic [DIV_W-1:0] bpm_num(input int fs_hz);
    int prod;
    prod = 32'sd60 * fs_hz;
    return prod[DIV_W-1:0];
  endfunction

endpackage

// File: rtl/ecg_bpm_divider.sv
// Sequential restoring divider: NUM / divisor, one quotient bit per clock,
// result clamped to 8 bits. A start while busy restarts with the new divisor.
module ecg_bpm_divider
  import ecg_pkg::*;
#(
  parameter logic [DIV_W-1:0] NUM = 16'd30000
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [BPM_W-1:0] quotient
);

  localparam logic [DIV_W-1:0] BPM_MAX = 16'd255;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [BPM_W-1:0] res_q, res_d;
  logic [DIV_W:0]   rem_sh, div_ext;
  logic [DIV_W-1:0] quo_sh, trial;

  always_comb begin
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    res_d   = res_q;
    rem_sh  = {rem_q, quo_q[DIV_W-1]};
    quo_sh  = {quo_q[DIV_W-2:0], 1'b0};
    div_ext = {{(DIV_W+1-CNT_W){1'b0}}, div_q};
    // The true difference is below the divisor, so the low bits are exact.
    trial   = rem_sh[DIV_W-1:0] - div_ext[DIV_W-1:0];
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = 5'd16;
      rem_d  = {DIV_W{1'b0}};
      quo_d  = NUM;
      div_d  = divisor;
    end else if (busy_q) begin
      if (rem_sh >= div_ext) begin
        rem_d = trial;
        quo_d = {quo_sh[DIV_W-1:1], 1'b1};
      end else begin
        rem_d = rem_sh[DIV_W-1:0];
        quo_d = quo_sh;
      end
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        res_d  = (quo_d > BPM_MAX) ? 8'hFF : quo_d[BPM_W-1:0];
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= 5'd0;
      rem_q  <= {DIV_W{1'b0}};
      quo_q  <= {DIV_W{1'b0}};
      div_q  <= {CNT_W{1'b0}};
      res_q  <= {BPM_W{1'b0}};
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      res_q  <= res_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = res_q;

endmodule

// File: rtl/ecg_rpeak_rr_detector.sv
// R-peak detector: threshold crossing with max tracking, refractory hold-off,
// over-wide excursion rejection, R-R interval measurement and BPM conversion.
module ecg_rpeak_rr_detector
  import ecg_pkg::*;
#(
  parameter int FS_HZ     = 500,
  parameter int MAX_WIDTH = 100
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] threshold,
  input  logic [CNT_W-1:0]    refractory_samples,
  output logic                peak_pulse,
  output logic [CNT_W-1:0]    rr_interval,
  output logic                rr_valid,
  output logic [BPM_W-1:0]    bpm,
  output logic                bpm_valid,
  output logic                artifact,
  output logic                no_beat
);

  localparam int               WID_W   = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
  localparam logic [WID_W-1:0] WID_MAX = WID_W'(MAX_WIDTH);
  localparam logic [DIV_W-1:0] NUM     = bpm_num(FS_HZ);

  det_state_e          state_q, state_d;
  logic [CNT_W-1:0]    since_peak_q, since_peak_d;
  logic                have_ref_q, have_ref_d;
  logic                no_beat_q, no_beat_d;
  logic [SAMPLE_W-1:0] max_val_q, max_val_d;
  logic [CNT_W-1:0]    max_off_q, max_off_d;
  logic [WID_W-1:0]    width_q, width_d;
  logic [CNT_W-1:0]    refr_q, refr_d;
  logic                peak_pulse_q, peak_pulse_d;
  logic [CNT_W-1:0]    rr_interval_q, rr_interval_d;
  logic                rr_valid_q, rr_valid_d;
  logic                artifact_q, artifact_d;
  logic [CNT_W-1:0]    snew;
  logic                above;
  logic                div_busy, div_done;

  always_comb begin
    state_d       = state_q;
    since_peak_d  = since_peak_q;
    have_ref_d    = have_ref_q;
    no_beat_d     = no_beat_q;
    max_val_d     = max_val_q;
    max_off_d     = max_off_q;
    width_d       = width_q;
    refr_d        = refr_q;
    rr_interval_d = rr_interval_q;
    peak_pulse_d  = 1'b0;
    rr_valid_d    = 1'b0;
    artifact_d    = 1'b0;
    snew  = (since_peak_q == CNT_SAT) ? CNT_SAT : since_peak_q + 13'd1;
    above = (sample >= threshold);
    if (sample_valid) begin
      since_peak_d = snew;
      if (snew == CNT_SAT) begin
        no_beat_d  = 1'b1;
        have_ref_d = 1'b0;
      end else begin
        no_beat_d  = no_beat_q;
      end
      case (state_q)
        BELOW: begin
          if (above) begin
            state_d   = ABOVE;
            max_val_d = sample;
            max_off_d = snew;
            width_d   = 16'd1;
          end else begin
            state_d   = BELOW;
          end
        end
        ABOVE: begin
          if (above) begin
            if (width_q >= WID_MAX) begin
              state_d    = ARTIFACT;
              artifact_d = 1'b1;
            end else if (sample > max_val_q) begin
              width_d   = width_q + 16'd1;
              max_val_d = sample;
              max_off_d = snew;
            end else begin
              width_d   = width_q + 16'd1;
            end
          end else begin
            // Peak accepted: restart the interval count from the maximum.
            peak_pulse_d = 1'b1;
            if (have_ref_q) begin
              rr_interval_d = max_off_q;
              rr_valid_d    = 1'b1;
            end else begin
              rr_interval_d = rr_interval_q;
            end
            since_peak_d = snew - max_off_q;
            have_ref_d   = 1'b1;
            no_beat_d    = 1'b0;
            refr_d       = refractory_samples;
            state_d      = (refractory_samples == 13'd0) ? BELOW : REFRACT;
          end
        end
        REFRACT: begin
          refr_d  = refr_q - 13'd1;
          state_d = (refr_q == 13'd1) ? BELOW : REFRACT;
        end
        ARTIFACT: begin
          state_d = above ? ARTIFACT : BELOW;
        end
        default: begin
          state_d = BELOW;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q       <= BELOW;
      since_peak_q  <= {CNT_W{1'b0}};
      have_ref_q    <= 1'b0;
      no_beat_q     <= 1'b0;
      max_val_q     <= {SAMPLE_W{1'b0}};
      max_off_q     <= {CNT_W{1'b0}};
      width_q       <= {WID_W{1'b0}};
      refr_q        <= {CNT_W{1'b0}};
      peak_pulse_q  <= 1'b0;
      rr_interval_q <= {CNT_W{1'b0}};
      rr_valid_q    <= 1'b0;
      artifact_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      since_peak_q  <= since_peak_d;
      have_ref_q    <= have_ref_d;
      no_beat_q     <= no_beat_d;
      max_val_q     <= max_val_d;
      max_off_q     <= max_off_d;
      width_q       <= width_d;
      refr_q        <= refr_d;
      peak_pulse_q  <= peak_pulse_d;
      rr_interval_q <= rr_interval_d;
      rr_valid_q    <= rr_valid_d;
      artifact_q    <= artifact_d;
    end
  end

  ecg_bpm_divider #(
    .NUM (NUM)
  ) u_div (
    .clk_in   (clk_in),
    .reset    (reset),
    .start    (rr_valid_q),
    .divisor  (rr_interval_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (bpm)
  );

  assign peak_pulse  = peak_pulse_q;
  assign rr_interval = rr_interval_q;
  assign rr_valid    = rr_valid_q;
  assign bpm_valid   = div_done & ~div_busy;
  assign artifact    = artifact_q;
  assign no_beat     = no_beat_q;

endmodule

// File: tb/tb_ecg_rpeak_rr_detector.sv
// Directed bench for ecg_rpeak_rr_detector: event counters sampled on the
// falling edge, compared against hand-computed beat/interval/BPM values.
module tb_ecg_rpeak_rr_detector;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] sample = 16'd200;
  logic [15:0] threshold = 16'd1000;
  logic [12:0] refractory_samples = 13'd100;
  logic        peak_pulse, rr_valid, bpm_valid, artifact, no_beat;
  logic [12:0] rr_interval;
  logic [7:0]  bpm;

  int n_total = 0, n_bad = 0;
  int n_peak = 0, n_rr = 0, n_bpm = 0, n_art = 0, pulse_err = 0;
  int cyc = 0, rr_cyc = 0, bpm_cyc = 0, last_rr = 0, last_bpm = 0;
  logic p_peak = 1'b0, p_rr = 1'b0, p_bpm = 1'b0, p_art = 1'b0;
  int b_snap, r_snap;
  logic seen;

  ecg_rpeak_rr_detector dut (
    .clk_in             (clk_in),
    .reset              (reset),
    .sample_valid       (sample_valid),
    .sample             (sample),
    .threshold          (threshold),
    .refractory_samples (refractory_samples),
    .peak_pulse         (peak_pulse),
    .rr_interval        (rr_interval),
    .rr_valid           (rr_valid),
    .bpm                (bpm),
    .bpm_valid          (bpm_valid),
    .artifact           (artifact),
    .no_beat            (no_beat)
  );

  always #5 clk_in = ~clk_in;

  // Event monitor: counts pulses and records the latest values and cycles.
  always @(negedge clk_in) begin
    cyc <= cyc + 1;
    if (peak_pulse) n_peak <= n_peak + 1;
    if (rr_valid) begin
      n_rr    <= n_rr + 1;
      last_rr <= int'(rr_interval);
      rr_cyc  <= cyc;
    end
    if (bpm_valid) begin
      n_bpm    <= n_bpm + 1;
      last_bpm <= int'(bpm);
      bpm_cyc  <= cyc;
    end
    if (artifact) n_art <= n_art + 1;
    if ((peak_pulse && p_peak) || (rr_valid && p_rr) || (bpm_valid && p_bpm) || (artifact && p_art))
      pulse_err <= pulse_err + 1;
    p_peak <= peak_pulse;
    p_rr   <= rr_valid;
    p_bpm  <= bpm_valid;
    p_art  <= artifact;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] s);
    @(negedge clk_in);
    sample_valid = 1'b1;
    sample       = s;
  endtask

  task automatic send_n(input logic [15:0] s, input int n);
    for (int i = 0; i < n; i++) send(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      sample_valid = 1'b0;
    end
  endtask

  task automatic settle();
    idle(2);
    @(posedge clk_in);
    #2;
  endtask

  task automatic exc();
    send(16'd1500);
    send(16'd2000);
    send(16'd1200);
  endtask

  // One beat: excursion with its maximum at offset 1, 500 samples long.
  task automatic beat();
    exc();
    send_n(16'd200, 497);
  endtask

  task automatic short_beat();
    exc();
    send_n(16'd200, 97);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      reset        = 1'b1;
      sample_valid = 1'($urandom_range(0, 1));
      sample       = 16'($urandom);
    end
    @(negedge clk_in);
    reset        = 1'b0;
    sample_valid = 1'b0;
    sample       = 16'd200;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    settle();
    check_eq("reset_outputs",
             int'({peak_pulse, rr_valid, bpm_valid, artifact, no_beat, rr_interval, bpm}), 0);

    // First beat after reset: peak but no interval yet.
    send_n(16'd200, 10);
    beat();
    settle();
    check_eq("first_peak", n_peak, 1);
    check_eq("first_no_rr", n_rr, 0);

    beat();
    settle();
    check_eq("beat2_peaks", n_peak, 2);
    check_eq("beat2_rr_cnt", n_rr, 1);
    check_eq("beat2_rr", last_rr, 500);
    check_eq("beat2_bpm_cnt", n_bpm, 1);
    check_eq("beat2_bpm", last_bpm, 60);
    check_eq("bpm_latency", bpm_cyc - rr_cyc, 17);

    beat();
    // Second excursion 50 samples in lands inside the refractory window.
    exc();
    send_n(16'd200, 47);
    exc();
    send_n(16'd200, 447);
    beat();
    settle();
    check_eq("refr_peaks", n_peak, 5);
    check_eq("refr_rr_cnt", n_rr, 4);
    check_eq("refr_rr", last_rr, 500);

    // Artifact: 150 wide samples, rejected on the 101st.
    send_n(16'd200, 100);
    send_n(16'd3000, 100);
    settle();
    check_eq("art_at_100", n_art, 0);
    send(16'd3000);
    settle();
    check_eq("art_at_101", n_art, 1);
    send_n(16'd3000, 49);
    send_n(16'd200, 250);
    beat();
    settle();
    check_eq("art_no_peak", n_peak, 6);
    check_eq("art_rr", last_rr, 1000);
    check_eq("art_bpm", last_bpm, 30);

    // Timeout: since-peak counter saturates.
    send_n(16'd200, 8000);
    settle();
    check_eq("timeout_no_beat", int'(no_beat), 1);
    beat();
    settle();
    check_eq("timeout_cleared", int'(no_beat), 0);
    check_eq("timeout_no_rr", n_rr, 5);
    beat();
    settle();
    check_eq("post_timeout_rr", last_rr, 498);
    check_eq("post_timeout_bpm", last_bpm, 60);
    check_eq("post_timeout_bcnt", n_bpm, 6);

    // Clamp with refractory disabled.
    refractory_samples = 13'd0;
    short_beat();
    short_beat();
    short_beat();
    settle();
    check_eq("clamp_rr", last_rr, 100);
    check_eq("clamp_bpm", last_bpm, 255);
    check_eq("clamp_bcnt", n_bpm, 9);

    // Two intervals two cycles apart: divider restarts, one result.
    send_n(16'd200, 400);
    send(16'd2000);
    send(16'd200);
    send(16'd2000);
    send(16'd200);
    send_n(16'd200, 50);
    settle();
    check_eq("restart_rr_cnt", n_rr, 11);
    check_eq("restart_rr", last_rr, 2);
    check_eq("restart_bcnt", n_bpm, 10);
    check_eq("restart_bpm", last_bpm, 255);

    // Reset mid-division aborts the pending result.
    refractory_samples = 13'd100;
    do_reset();
    settle();
    b_snap = n_bpm;
    r_snap = n_rr;
    send_n(16'd200, 10);
    beat();
    exc();
    send(16'd200);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_in);
      sample_valid = 1'b0;
      if (rr_valid) seen = 1'b1;
    end
    check_eq("abort_rr_seen", int'(seen), 1);
    repeat (5) @(negedge clk_in);
    reset = 1'b1;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    idle(40);
    settle();
    check_eq("abort_rr_cnt", n_rr, r_snap + 1);
    check_eq("abort_no_bpm", n_bpm, b_snap);
    check_eq("abort_bpm_zero", int'(bpm), 0);
    check_eq("abort_rr_zero", int'(rr_interval), 0);

    check_eq("pulse_width", pulse_err, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
